// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// multicycle_control_pkg -- opcode, ALUOp and state encodings shared by control and datapath
// rev 1.0
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_SLTI  = 4'h2;
  localparam logic [3:0] OP_LW    = 4'h3;
  localparam logic [3:0] OP_SW    = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_SLT    = 2'b11;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_BEQ) || (op == OP_HALT);
  endfunction

  function automatic logic [1:0] alu_op_for(input logic [3:0] op);
    case (op)
      OP_RTYPE: return ALUOP_RTYPE;
      OP_SLTI:  return ALUOP_SLT;
      OP_BEQ:   return ALUOP_BRANCH;
      default:  return ALUOP_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_decode.sv
`default_nettype none
// control_decode -- combinational map from (state, latched op) to datapath controls
// rev 1.0
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] op,
  input  logic       mem_ready,
  output logic       reg_dst,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       illegal_op,
  output logic       halted
);

  logic is_lw, is_sw, is_beq, uses_imm;

  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign uses_imm = (op == OP_ADDI) || (op == OP_SLTI) || is_lw || is_sw;

  always_comb begin
    reg_dst    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state)
      ST_DECODE: begin
        if (!is_legal_op(op)) begin
          illegal_op = 1'b1;
          pc_write   = 1'b1;
        end
      end
      ST_EXEC: begin
        alu_op   = alu_op_for(op);
        alu_src  = uses_imm;
        branch   = is_beq;
        pc_write = is_beq;
      end
      ST_MEM: begin
        alu_op    = alu_op_for(op);
        alu_src   = uses_imm;
        mem_read  = is_lw;
        mem_write = is_sw;
        // A store retires on the MEM cycle in which memory completes.
        pc_write  = is_sw && mem_ready;
      end
      ST_WB: begin
        alu_op     = alu_op_for(op);
        alu_src    = uses_imm;
        reg_write  = 1'b1;
        reg_dst    = (op == OP_RTYPE);
        mem_to_reg = is_lw;
        pc_write   = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// multicycle_control -- multicycle CPU control FSM with retired-instruction counter
// rev 1.0
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic        MemReady,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        PCWrite,
  output logic        IllegalOp,
  output logic        Halted,
  output logic [15:0] InstrCount
);

  state_t     state, state_next;
  logic [3:0] op;

  // Upper opcode bits carry no meaning for this control unit.
  logic unused_opcode_hi;
  assign unused_opcode_hi = ^opcode[5:4];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_FETCH;
      op         <= OP_RTYPE;
      InstrCount <= 16'd0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH) op <= opcode[3:0];
      if (PCWrite) InstrCount <= InstrCount + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_HALT)       state_next = ST_HALT;
        else if (!is_legal_op(op)) state_next = ST_FETCH;
        else                     state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (op == OP_LW || op == OP_SW) state_next = ST_MEM;
        else if (op == OP_BEQ)          state_next = ST_FETCH;
        else                            state_next = ST_WB;
      end
      ST_MEM: begin
        if (MemReady) state_next = (op == OP_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  control_decode u_decode (
    .state      (state),
    .op         (op),
    .mem_ready  (MemReady),
    .reg_dst    (RegDst),
    .branch     (Branch),
    .mem_read   (MemRead),
    .mem_write  (MemWrite),
    .reg_write  (RegWrite),
    .mem_to_reg (MemToReg),
    .alu_src    (ALUSrc),
    .alu_op     (ALUOp),
    .pc_write   (PCWrite),
    .illegal_op (IllegalOp),
    .halted     (Halted)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// tb_multicycle_control -- randomized self-checking bench with a per-instruction trace model
// rev 1.0
module tb_multicycle_control;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       illegal;
    logic       halted;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        MemReady = 1'b0;
  logic        RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc;
  logic [1:0]  ALUOp;
  logic        PCWrite, IllegalOp, Halted;
  logic [15:0] InstrCount;

  multicycle_control dut (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .MemReady(MemReady),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .PCWrite(PCWrite), .IllegalOp(IllegalOp), .Halted(Halted), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  logic [11:0] obs_now;
  assign obs_now = {RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
                    ALUOp, PCWrite, IllegalOp, Halted};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_cnt = 16'd0;
  logic [11:0] exp_q[$];
  logic [15:0] ecnt_q[$];
  logic        mr_q[$];
  logic [11:0] obs_q[$];
  logic [15:0] cnt_q[$];

  // Expected per-cycle trace of one instruction, starting in its FETCH cycle.
  // For HALT, 'extra' is the number of halted cycles to observe; otherwise MEM wait cycles.
  task automatic model_instr(input logic [5:0] opc, input int extra);
    exp_t        z, e;
    logic [3:0]  op;
    logic [1:0]  alu;
    logic        imm;
    logic [15:0] c;
    z  = '0;
    op = opc[3:0];
    exp_q.delete(); ecnt_q.delete(); mr_q.delete();
    exp_q.push_back(z); mr_q.push_back(1'($urandom));
    if (op > 4'h5 && op != 4'hF) begin
      e = z; e.illegal = 1'b1; e.pc_write = 1'b1;
      exp_q.push_back(e); mr_q.push_back(1'($urandom));
    end else if (op == 4'hF) begin
      exp_q.push_back(z); mr_q.push_back(1'($urandom));
      e = z; e.halted = 1'b1;
      for (int k = 0; k < extra; k++) begin
        exp_q.push_back(e); mr_q.push_back(1'($urandom));
      end
    end else begin
      exp_q.push_back(z); mr_q.push_back(1'($urandom));
      alu = (op == 4'h0) ? 2'b10 : (op == 4'h5) ? 2'b01 : (op == 4'h2) ? 2'b11 : 2'b00;
      imm = (op != 4'h0) && (op != 4'h5);
      e = z; e.alu_op = alu; e.alu_src = imm;
      e.branch = (op == 4'h5); e.pc_write = (op == 4'h5);
      exp_q.push_back(e); mr_q.push_back(1'($urandom));
      if (op == 4'h3 || op == 4'h4) begin
        for (int w = 0; w <= extra; w++) begin
          e = z; e.alu_op = alu; e.alu_src = imm;
          e.mem_read = (op == 4'h3); e.mem_write = (op == 4'h4);
          e.pc_write = (op == 4'h4) && (w == extra);
          exp_q.push_back(e); mr_q.push_back(w == extra);
        end
      end
      if (op != 4'h5 && op != 4'h4) begin
        e = z; e.alu_op = alu; e.alu_src = imm; e.reg_write = 1'b1;
        e.reg_dst = (op == 4'h0); e.mem_to_reg = (op == 4'h3); e.pc_write = 1'b1;
        exp_q.push_back(e); mr_q.push_back(1'($urandom));
      end
    end
    c = model_cnt;
    for (int i = 0; i < exp_q.size(); i++) begin
      ecnt_q.push_back(c);
      if (exp_q[i][2]) c = c + 16'd1;
    end
    model_cnt = c;
  endtask

  task automatic step(input logic rst, input logic mr, input logic [5:0] opc);
    @(negedge Clock);
    Reset = rst; MemReady = mr; opcode = opc;
    #1;
  endtask

  // Opcode is only meaningful in the FETCH cycle; other cycles get random junk.
  task automatic drive_instr(input logic [5:0] opc);
    obs_q.delete(); cnt_q.delete();
    for (int i = 0; i < mr_q.size(); i++) begin
      step(1'b0, mr_q[i], (i == 0) ? opc : 6'($urandom));
      obs_q.push_back(obs_now);
      cnt_q.push_back(InstrCount);
    end
  endtask

  task automatic test_reset();
    repeat (3) step(1'b1, 1'($urandom), 6'($urandom));
    model_cnt = 16'd0;
    model_instr(6'b001000, 0);
    drive_instr(6'b001000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL reset_ctrl cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
      n_checks++;
      if (cnt_q[i] !== ecnt_q[i]) begin
        n_fail++; $display("FAIL reset_count cyc%0d got %0d want %0d", i, cnt_q[i], ecnt_q[i]);
      end
    end
  endtask

  task automatic test_rtype();
    model_instr(6'b000000, 0);
    drive_instr(6'b000000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rtype_ctrl cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
      n_checks++;
      if (cnt_q[i] !== ecnt_q[i]) begin
        n_fail++; $display("FAIL rtype_count cyc%0d got %0d want %0d", i, cnt_q[i], ecnt_q[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    model_instr(6'b010011, 3);
    drive_instr(6'b010011);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL lw_wait_ctrl cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
      n_checks++;
      if (cnt_q[i] !== ecnt_q[i]) begin
        n_fail++; $display("FAIL lw_wait_count cyc%0d got %0d want %0d", i, cnt_q[i], ecnt_q[i]);
      end
    end
  endtask

  task automatic test_beq_illegal();
    logic [5:0] seq [3];
    seq[0] = 6'b000101; seq[1] = 6'b001000; seq[2] = 6'b100000;
    for (int s = 0; s < 3; s++) begin
      model_instr(seq[s], 0);
      drive_instr(seq[s]);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL beq_ill_ctrl op%b cyc%0d got %b want %b", seq[s], i, obs_q[i], exp_q[i]);
        end
        n_checks++;
        if (cnt_q[i] !== ecnt_q[i]) begin
          n_fail++; $display("FAIL beq_ill_count op%b cyc%0d got %0d want %0d", seq[s], i, cnt_q[i], ecnt_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] opc;
    int         waits;
    for (int n = 0; n < 40; n++) begin
      opc   = {2'($urandom), 4'($urandom_range(0, 14))};
      waits = $urandom_range(0, 3);
      model_instr(opc, waits);
      drive_instr(opc);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL b2b_ctrl op%b cyc%0d got %b want %b", opc, i, obs_q[i], exp_q[i]);
        end
        n_checks++;
        if (cnt_q[i] !== ecnt_q[i]) begin
          n_fail++; $display("FAIL b2b_count op%b cyc%0d got %0d want %0d", opc, i, cnt_q[i], ecnt_q[i]);
        end
      end
    end
  endtask

  task automatic test_halt();
    model_instr(6'b101111, 20);
    drive_instr(6'b101111);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL halt_ctrl cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
      n_checks++;
      if (cnt_q[i] !== ecnt_q[i]) begin
        n_fail++; $display("FAIL halt_count cyc%0d got %0d want %0d", i, cnt_q[i], ecnt_q[i]);
      end
    end
    step(1'b1, 1'($urandom), 6'($urandom));
    model_cnt = 16'd0;
    model_instr(6'b000001, 0);
    drive_instr(6'b000001);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL halt_reset_ctrl cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
      n_checks++;
      if (cnt_q[i] !== ecnt_q[i]) begin
        n_fail++; $display("FAIL halt_reset_count cyc%0d got %0d want %0d", i, cnt_q[i], ecnt_q[i]);
      end
    end
  endtask

  task automatic test_reset_in_mem();
    step(1'b0, 1'b0, 6'b000100);
    step(1'b0, 1'b0, 6'($urandom));
    step(1'b0, 1'b0, 6'($urandom));
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 6'($urandom));
      n_checks++;
      if (MemWrite !== 1'b1 || PCWrite !== 1'b0) begin
        n_fail++; $display("FAIL sw_stall wait%0d got MemWrite=%b PCWrite=%b want 1/0", k, MemWrite, PCWrite);
      end
    end
    // MemReady rises on the reset edge itself: reset must still win.
    step(1'b1, 1'b1, 6'($urandom));
    model_cnt = 16'd0;
    model_instr(6'b000010, 0);
    drive_instr(6'b000010);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mem_reset_ctrl cyc%0d got %b want %b", i, obs_q[i], exp_q[i]);
      end
      n_checks++;
      if (cnt_q[i] !== ecnt_q[i]) begin
        n_fail++; $display("FAIL mem_reset_count cyc%0d got %0d want %0d", i, cnt_q[i], ecnt_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_rtype();
    test_beq_illegal();
    test_back_to_back();
    test_halt();
    test_reset_in_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
